// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU, debug/loader) and the RAM.
// The arbiter uses the slave view; the master view is for whatever drives the requests and RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_lock;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  ram_rdata,
    output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output ram_rdata,
    input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU memory path and the debug/loader port, running
// one access at a time: IDLE -> ISSUE -> (read: WAIT x RD_LAT) -> ACK -> IDLE.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant_dbg;

  // Debug wins when alone, when locked, or on a round-robin tie after a CPU grant.
  always_comb begin
    grant_dbg = bus.dbg_req &&
                (!bus.cpu_req || bus.dbg_lock || ((CPU_PRIO == 0) && !last_owner_q));
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dbg_req) begin
          owner_d      = grant_dbg;
          last_owner_d = grant_dbg;
          we_d         = grant_dbg ? bus.dbg_we    : bus.cpu_we;
          addr_d       = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
          wdata_d      = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StAck;
        end else begin
          cnt_d   = 3'(RD_LAT - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          if (owner_q) dbg_rdata_d = bus.ram_rdata;
          else         cpu_rdata_d = bus.ram_rdata;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= 3'd0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Address and write data hold the latched request outside ISSUE rather than floating.
  always_comb begin
    bus.ram_addr  = addr_q;
    bus.ram_wdata = wdata_q;
    bus.ram_we    = (state_q == StIssue) && we_q;
    bus.ram_re    = (state_q == StIssue) && !we_q;
    bus.cpu_ack   = (state_q == StAck) && !owner_q;
    bus.dbg_ack   = (state_q == StAck) && owner_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dbg_rdata = dbg_rdata_q;
    bus.busy      = (state_q != StIdle);
    bus.owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a 2-cycle RAM model and a
// CPU-priority instance used for tie arbitration.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p_bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .CPU_PRIO(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2), .CPU_PRIO(1)) dut_p (
    .clk   (clk),
    .reset (reset),
    .bus   (p_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data is presented only in the cycle exactly two cycles after ram_re.
  logic [7:0] mem [256];
  logic [7:0] pipe1, pipe2;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    pipe1 <= bus.ram_re ? mem[bus.ram_addr] : 8'h00;
    pipe2 <= pipe1;
  end
  assign bus.ram_rdata   = pipe2;
  assign p_bus.ram_rdata = 8'h00;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    bus.cpu_req = 0; bus.dbg_req = 0; bus.dbg_lock = 0;
    p_bus.cpu_req = 0; p_bus.dbg_req = 0; p_bus.dbg_lock = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drop_all();
    bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    p_bus.cpu_we = 0; p_bus.cpu_addr = 0; p_bus.cpu_wdata = 0;
    p_bus.dbg_we = 0; p_bus.dbg_addr = 0; p_bus.dbg_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", bus.busy); end
    checks++; if ({bus.ram_we, bus.ram_re} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b want 00", {bus.ram_we, bus.ram_re}); end
    checks++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b want 00", {bus.cpu_ack, bus.dbg_ack}); end
    checks++; if ({bus.ram_addr, bus.ram_wdata} !== 16'h0000) begin errors++; $display("FAIL rst_ram_bus got %h want 0000", {bus.ram_addr, bus.ram_wdata}); end
    checks++; if ({bus.cpu_rdata, bus.dbg_rdata} !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h want 0000", {bus.cpu_rdata, bus.dbg_rdata}); end
    checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL rst_owner got %0b want 0", bus.owner); end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_write();
    next_cycle();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_c0_busy got %0b want 0", bus.busy); end
    @(negedge clk);
    checks++; if ({bus.ram_we, bus.ram_re} !== 2'b10) begin errors++; $display("FAIL wr_c1_strobes got %b want 10", {bus.ram_we, bus.ram_re}); end
    checks++; if ({bus.ram_addr, bus.ram_wdata} !== 16'h10A5) begin errors++; $display("FAIL wr_c1_bus got %h want 10a5", {bus.ram_addr, bus.ram_wdata}); end
    checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL wr_c1_owner got %0b want 0", bus.owner); end
    @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b10) begin errors++; $display("FAIL wr_c2_acks got %b want 10", {bus.cpu_ack, bus.dbg_ack}); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL wr_c2_we got %0b want 0", bus.ram_we); end
    next_cycle();
    bus.cpu_req = 0;
    @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.busy} !== 2'b00) begin errors++; $display("FAIL wr_c3_idle got %b want 00", {bus.cpu_ack, bus.busy}); end
  endtask

  task automatic test_read();
    next_cycle();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.ram_re, bus.ram_we} !== 2'b10) begin errors++; $display("FAIL rd_c1_strobes got %b want 10", {bus.ram_re, bus.ram_we}); end
    checks++; if (bus.ram_addr !== 8'h10) begin errors++; $display("FAIL rd_c1_addr got %h want 10", bus.ram_addr); end
    @(negedge clk);
    checks++; if ({bus.ram_re, bus.busy} !== 2'b01) begin errors++; $display("FAIL rd_c2_wait got %b want 01", {bus.ram_re, bus.busy}); end
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_c3_early_ack got %0b want 0", bus.cpu_ack); end
    @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b10) begin errors++; $display("FAIL rd_c4_acks got %b want 10", {bus.cpu_ack, bus.dbg_ack}); end
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_c4_rdata got %h want a5", bus.cpu_rdata); end
    next_cycle();
    bus.cpu_req = 0;
    @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.cpu_rdata} !== 9'h0A5) begin errors++; $display("FAIL rd_c5_hold got %h want 0a5", {bus.cpu_ack, bus.cpu_rdata}); end
  endtask

  task automatic test_dbg_port();
    next_cycle();
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 8'h20; bus.dbg_wdata = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({bus.ram_we, bus.owner, bus.ram_addr, bus.ram_wdata} !== 18'h3203C) begin errors++; $display("FAIL dbg_wr_issue got %h want 3203c", {bus.ram_we, bus.owner, bus.ram_addr, bus.ram_wdata}); end
    @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b01) begin errors++; $display("FAIL dbg_wr_acks got %b want 01", {bus.cpu_ack, bus.dbg_ack}); end
    next_cycle();
    bus.dbg_we = 0;
    repeat (5) @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.dbg_ack} !== 2'b01) begin errors++; $display("FAIL dbg_rd_acks got %b want 01", {bus.cpu_ack, bus.dbg_ack}); end
    checks++; if ({bus.dbg_rdata, bus.cpu_rdata} !== 16'h3CA5) begin errors++; $display("FAIL dbg_rd_rdata got %h want 3ca5", {bus.dbg_rdata, bus.cpu_rdata}); end
    next_cycle();
    bus.dbg_req = 0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h11;
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 8'h31; bus.dbg_wdata = 8'h22;
    p_bus.cpu_req = 1; p_bus.cpu_we = 1; p_bus.cpu_addr = 8'h30; p_bus.cpu_wdata = 8'h11;
    p_bus.dbg_req = 1; p_bus.dbg_we = 1; p_bus.dbg_addr = 8'h31; p_bus.dbg_wdata = 8'h22;
    for (int t = 0; t < 4; t++) begin
      logic exp_dbg;
      logic found;
      exp_dbg = t[0];
      found = 0;
      for (int k = 0; k < 6 && !found; k++) begin
        @(negedge clk);
        if (bus.ram_we === 1'b1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL tie_grant%0d got no ram_we want ram_we within 6 cycles", t); end
      checks++; if (bus.owner !== exp_dbg) begin errors++; $display("FAIL tie_owner%0d got %0b want %0b", t, bus.owner, exp_dbg); end
      checks++; if ({p_bus.ram_we, p_bus.owner} !== 2'b10) begin errors++; $display("FAIL prio_grant%0d got %b want 10", t, {p_bus.ram_we, p_bus.owner}); end
      @(negedge clk);
      checks++; if ({bus.cpu_ack, bus.dbg_ack} !== {!exp_dbg, exp_dbg}) begin errors++; $display("FAIL tie_acks%0d got %b want %b", t, {bus.cpu_ack, bus.dbg_ack}, {!exp_dbg, exp_dbg}); end
      checks++; if ({p_bus.cpu_ack, p_bus.dbg_ack} !== 2'b10) begin errors++; $display("FAIL prio_acks%0d got %b want 10", t, {p_bus.cpu_ack, p_bus.dbg_ack}); end
    end
    next_cycle();
    drop_all();
    @(negedge clk);
    checks++; if ({bus.busy, p_bus.busy} !== 2'b00) begin errors++; $display("FAIL tie_drain got %b want 00", {bus.busy, p_bus.busy}); end
  endtask

  task automatic test_lock();
    next_cycle();
    bus.cpu_req = 1; bus.dbg_req = 1; bus.dbg_lock = 1;
    for (int t = 0; t < 4; t++) begin
      logic exp_dbg;
      logic found;
      exp_dbg = (t < 3);
      found = 0;
      for (int k = 0; k < 6 && !found; k++) begin
        @(negedge clk);
        if (bus.ram_we === 1'b1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL lock_grant%0d got no ram_we want ram_we within 6 cycles", t); end
      checks++; if (bus.owner !== exp_dbg) begin errors++; $display("FAIL lock_owner%0d got %0b want %0b", t, bus.owner, exp_dbg); end
      @(negedge clk);
      checks++; if ({bus.cpu_ack, bus.dbg_ack} !== {!exp_dbg, exp_dbg}) begin errors++; $display("FAIL lock_acks%0d got %b want %b", t, {bus.cpu_ack, bus.dbg_ack}, {!exp_dbg, exp_dbg}); end
      next_cycle();
      if (t == 2) bus.dbg_lock = 0;
    end
    drop_all();
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    next_cycle();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    repeat (5) @(negedge clk);
    checks++; if ({bus.cpu_ack, bus.cpu_rdata} !== 9'h1A5) begin errors++; $display("FAIL rstw_preload got %h want 1a5", {bus.cpu_ack, bus.cpu_rdata}); end
    next_cycle();
    bus.cpu_req = 0;
    next_cycle();
    bus.cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.ram_re !== 1'b1) begin errors++; $display("FAIL rstw_issue got %0b want 1", bus.ram_re); end
    next_cycle();
    reset = 1;
    @(negedge clk);
    next_cycle();
    reset = 0; bus.cpu_req = 0;
    @(negedge clk);
    checks++; if ({bus.busy, bus.ram_re, bus.cpu_ack} !== 3'b000) begin errors++; $display("FAIL rstw_idle got %b want 000", {bus.busy, bus.ram_re, bus.cpu_ack}); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rstw_rdata got %h want 00", bus.cpu_rdata); end
    @(negedge clk);
    checks++; if ({bus.busy, bus.cpu_ack} !== 2'b00) begin errors++; $display("FAIL rstw_no_ack got %b want 00", {bus.busy, bus.cpu_ack}); end
  endtask

  task automatic test_drop();
    int re_cnt, we_cnt, cack_cnt, dack_cnt;
    re_cnt = 0; we_cnt = 0; cack_cnt = 0; dack_cnt = 0;
    next_cycle();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      re_cnt += int'(bus.ram_re);
      we_cnt += int'(bus.ram_we);
      cack_cnt += int'(bus.cpu_ack);
      dack_cnt += int'(bus.dbg_ack);
      if (k == 1) begin
        next_cycle();
        bus.cpu_req = 0;
      end
    end
    checks++; if (re_cnt != 1 || we_cnt != 0) begin errors++; $display("FAIL drop_strobes got re=%0d we=%0d want re=1 we=0", re_cnt, we_cnt); end
    checks++; if (cack_cnt != 1 || dack_cnt != 0) begin errors++; $display("FAIL drop_acks got cpu=%0d dbg=%0d want cpu=1 dbg=0", cack_cnt, dack_cnt); end
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL drop_rdata got %h want a5", bus.cpu_rdata); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_write();
    test_read();
    test_dbg_port();
    test_tie();
    test_lock();
    test_reset_wait();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
